tx_slice_scheduler: RTL
=======================

# tx_slice_scheduler

Time-division scheduler that generates the four per-queue transmit-permission windows `slice_en0..3` consumed by the CSMA/CA block, where each is ANDed with `backoff_done` to form `high_tx_allowed0..3`. Each slice runs its own period counter clocked by the 1 µs TSF tick. The slice is open inside a programmable `[start, end)` window, minus a guard interval, so a transmission cannot be granted too close to the window end. Configuration is shadowed and applied only at period boundaries, or immediately on an explicit load strobe.

## Interface
Parameters:
- `SLICE_W`, default 20: width of all µs time quantities (period, start, end, guard, counters).

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `tsf_pulse_1M` in 1: one-cycle strobe, once per µs.
- `sched_enable` in 1: 0 forces every `slice_en` to 1 (scheduling bypassed); counters keep running.
- `resync` in 1: one-cycle strobe; zeroes all four counters and leaves shadows unchanged (used on TSF write).
- `cfg_load` in 1: one-cycle strobe; copies all config inputs into the shadows and zeroes all counters.
- `slice_total0..3` in SLICE_W: period of slice i in µs; 0 means slice i is unsliced.
- `slice_start0..3` in SLICE_W: window open offset in µs.
- `slice_end0..3` in SLICE_W: window close offset in µs, exclusive.
- `guard_time` in SLICE_W: minimum remaining window, in µs, required to keep a slice open. Shared by all slices.
- `slice_en0..3` out 1: transmit permission per queue.
- `slice_wrap0..3` out 1: one-cycle strobe at the period boundary of slice i.

## Operation
- Per slice i, the shadow set is `tot`, `st`, `en`, plus a counter `cnt`. There is one shared `guard` shadow.
- Counter, at each `tsf_pulse_1M`:
  - if `tot == 0`: `cnt` holds at 0.
  - else if `cnt >= tot-1`: `cnt` goes to 0 and `slice_wrap_i` pulses. The `>=` also covers `tot` being reduced below `cnt` via `cfg_load`.
  - otherwise `cnt` increments.
- Shadow update on wrap: in the same cycle that `slice_wrap_i` is generated, slice i's `tot`, `st`, `en` load from the live inputs, and `guard` loads as well. Live inputs are otherwise ignored.
- Window decision, registered:
  - `slice_en_i = !sched_enable || tot==0 || (st <= cnt && cnt + guard < en)`.
  - The sum is computed in SLICE_W+1 bits, so it has no overflow.
- Degenerate windows:
  - `st >= en` gives a permanently closed window.
  - `en > tot` behaves as a window open up to `tot-1`.
  - Wrap-around windows (`st > en` meaning "open across the boundary") are not supported; program two slices instead.
- Priority within a cycle: `rstn` > `cfg_load` > `resync` > `tsf_pulse_1M`.
  - A tick coincident with `cfg_load` or `resync` is dropped.
  - `cfg_load` coincident with a wrap: `cfg_load` wins, and no `slice_wrap` is emitted.
- Reset values:
  - all `cnt` = 0; all shadows = 0 (every slice unsliced); `guard` = 0.
  - all `slice_en` = 1; all `slice_wrap` = 0.

## Timing
- `slice_en_i` reflects `cnt`/shadow state with 1 cycle of register latency. `cnt` changes in the cycle after the tick, so `slice_en_i` changes 2 cycles after the triggering `tsf_pulse_1M`.
- `slice_wrap_i` is asserted in the cycle immediately after the tick that wraps the counter, the same cycle `cnt` reads 0. Width is exactly 1 cycle.
- `cfg_load`: the new shadows and `cnt = 0` are visible the next cycle; `slice_en` reflects them one cycle later.
- `sched_enable` and `guard` affect `slice_en` with 1 cycle latency. `guard` takes effect only after the next wrap or `cfg_load`.
- Reset mid-window: `slice_en` returns to 1 on the cycle after `rstn` is sampled low.

## Structure
- Shared package holds:
  - `NUM_SLICE = 4`
  - default `SLICE_W`
  - the priority ordering of the `cfg_load`/`resync`/tick events, as named constants for the bench.
- Sub-module `slice_timer`: one counter, its shadows, the window comparator and the wrap strobe. The top instantiates it four times and owns the shared `guard` shadow and `sched_enable` bypass.
- 200–300 lines of RTL total.

## Test plan
- Reset, then no config → `slice_en0..3 = 1` and `slice_wrap = 0` for 1000 ticks; `sched_enable = 0` → still all 1.
- `cfg_load` with `tot0 = 10`, `st0 = 2`, `en0 = 5`, `guard = 0`, `sched_enable = 1` → `slice_en0` high while `cnt ∈ {2,3,4}`, i.e. 3 of every 10 ticks; `slice_wrap0` pulses every 10 ticks.
- Same config with `guard = 2` → `slice_en0` high only at `cnt = 2`; `guard = 3` → never high.
- Change live `slice_end0` to 8 at `cnt = 4` (no `cfg_load`) → current period still closes after `cnt = 4`; the next period is open for `cnt` 2–7.
- `resync` at `cnt = 7`, with a tick in the same cycle → `cnt = 0` next cycle, no `slice_wrap0`, shadows unchanged; coincident `cfg_load` + `resync` → new config loaded.
- `tot1 = 4`, `st1 = 3`, `en1 = 2` (`st >= en`) → `slice_en1` stays 0; `tot2 = 4`, `st2 = 0`, `en2 = 9` → `slice_en2` stays 1 with `slice_wrap2` pulsing every 4 ticks.

Source files
------------

// File: rtl/tx_slice_scheduler_pkg.sv
// Shared constants and event types for the per-queue transmit slice scheduler.
// Event priority is fixed here so the top, the timers and the bench agree.
package tx_slice_scheduler_pkg;

  localparam int NUM_SLICE   = 4;
  localparam int SLICE_W_DEF = 20;

  // Larger value wins when several events land in the same cycle.
  localparam int PRIO_NONE     = 0;
  localparam int PRIO_TICK     = 1;
  localparam int PRIO_RESYNC   = 2;
  localparam int PRIO_CFG_LOAD = 3;
  localparam int PRIO_RESET    = 4;

  typedef enum logic [1:0] {
    EVT_NONE     = 2'd0,
    EVT_TICK     = 2'd1,
    EVT_RESYNC   = 2'd2,
    EVT_CFG_LOAD = 2'd3
  } slice_evt_e;

  function automatic slice_evt_e pick_event(input logic cfg_load,
                                            input logic resync,
                                            input logic tick);
    slice_evt_e evt;
    evt = EVT_NONE;
    if (cfg_load)    evt = EVT_CFG_LOAD;
    else if (resync) evt = EVT_RESYNC;
    else if (tick)   evt = EVT_TICK;
    return evt;
  endfunction

endpackage

// File: rtl/tx_slice_scheduler_slice_timer.sv
// One slice: period counter, shadowed window config, wrap strobe and the
// combinational window comparator (registered by the top).
module slice_timer
  import tx_slice_scheduler_pkg::*;
#(
  parameter int SLICE_W = SLICE_W_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  slice_evt_e         evt,
  input  logic [SLICE_W-1:0] live_tot,
  input  logic [SLICE_W-1:0] live_st,
  input  logic [SLICE_W-1:0] live_en,
  input  logic [SLICE_W-1:0] guard,
  output logic               hit,
  output logic               wrap,
  output logic               wrap_now
);

  logic [SLICE_W-1:0] cnt_q, cnt_d;
  logic [SLICE_W-1:0] tot_q, tot_d;
  logic [SLICE_W-1:0] st_q, st_d;
  logic [SLICE_W-1:0] en_q, en_d;
  logic               wrap_q, wrap_d;
  logic [SLICE_W:0]   cnt_plus_guard;

  always_comb begin
    cnt_d  = cnt_q;
    tot_d  = tot_q;
    st_d   = st_q;
    en_d   = en_q;
    wrap_d = 1'b0;
    unique case (evt)
      EVT_CFG_LOAD: begin
        cnt_d = '0;
        tot_d = live_tot;
        st_d  = live_st;
        en_d  = live_en;
      end
      EVT_RESYNC: begin
        cnt_d = '0;
      end
      EVT_TICK: begin
        if (tot_q == '0) begin
          cnt_d = '0;
        end else if (cnt_q >= tot_q - SLICE_W'(1)) begin
          // >= also catches a period shortened below the running count
          cnt_d  = '0;
          wrap_d = 1'b1;
          tot_d  = live_tot;
          st_d   = live_st;
          en_d   = live_en;
        end else begin
          cnt_d = cnt_q + SLICE_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Extra bit keeps cnt + guard from wrapping at the top of the range.
  assign cnt_plus_guard = {1'b0, cnt_q} + {1'b0, guard};

  always_comb begin
    hit = (tot_q == '0) || ((st_q <= cnt_q) && (cnt_plus_guard < {1'b0, en_q}));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q  <= '0;
      tot_q  <= '0;
      st_q   <= '0;
      en_q   <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tot_q  <= tot_d;
      st_q   <= st_d;
      en_q   <= en_d;
      wrap_q <= wrap_d;
    end
  end

  assign wrap     = wrap_q;
  assign wrap_now = wrap_d;

endmodule

// File: rtl/tx_slice_scheduler.sv
// Four-queue time-division transmit scheduler; owns the shared guard shadow
// and the sched_enable bypass, and registers the per-slice window decision.
module tx_slice_scheduler
  import tx_slice_scheduler_pkg::*;
#(
  parameter int SLICE_W = SLICE_W_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               tsf_pulse_1M,
  input  logic               sched_enable,
  input  logic               resync,
  input  logic               cfg_load,
  input  logic [SLICE_W-1:0] slice_total0,
  input  logic [SLICE_W-1:0] slice_total1,
  input  logic [SLICE_W-1:0] slice_total2,
  input  logic [SLICE_W-1:0] slice_total3,
  input  logic [SLICE_W-1:0] slice_start0,
  input  logic [SLICE_W-1:0] slice_start1,
  input  logic [SLICE_W-1:0] slice_start2,
  input  logic [SLICE_W-1:0] slice_start3,
  input  logic [SLICE_W-1:0] slice_end0,
  input  logic [SLICE_W-1:0] slice_end1,
  input  logic [SLICE_W-1:0] slice_end2,
  input  logic [SLICE_W-1:0] slice_end3,
  input  logic [SLICE_W-1:0] guard_time,
  output logic               slice_en0,
  output logic               slice_en1,
  output logic               slice_en2,
  output logic               slice_en3,
  output logic               slice_wrap0,
  output logic               slice_wrap1,
  output logic               slice_wrap2,
  output logic               slice_wrap3
);

  slice_evt_e evt;

  logic [SLICE_W-1:0] live_tot [NUM_SLICE];
  logic [SLICE_W-1:0] live_st  [NUM_SLICE];
  logic [SLICE_W-1:0] live_en  [NUM_SLICE];

  logic [NUM_SLICE-1:0] hit;
  logic [NUM_SLICE-1:0] wrap;
  logic [NUM_SLICE-1:0] wrap_now;

  logic [SLICE_W-1:0]   guard_q, guard_d;
  logic [NUM_SLICE-1:0] slice_en_q, slice_en_d;

  assign evt = pick_event(cfg_load, resync, tsf_pulse_1M);

  assign live_tot[0] = slice_total0;
  assign live_tot[1] = slice_total1;
  assign live_tot[2] = slice_total2;
  assign live_tot[3] = slice_total3;
  assign live_st[0]  = slice_start0;
  assign live_st[1]  = slice_start1;
  assign live_st[2]  = slice_start2;
  assign live_st[3]  = slice_start3;
  assign live_en[0]  = slice_end0;
  assign live_en[1]  = slice_end1;
  assign live_en[2]  = slice_end2;
  assign live_en[3]  = slice_end3;

  for (genvar g = 0; g < NUM_SLICE; g++) begin : g_slice
    slice_timer #(.SLICE_W(SLICE_W)) u_timer (
      .clk      (clk),
      .rstn     (rstn),
      .evt      (evt),
      .live_tot (live_tot[g]),
      .live_st  (live_st[g]),
      .live_en  (live_en[g]),
      .guard    (guard_q),
      .hit      (hit[g]),
      .wrap     (wrap[g]),
      .wrap_now (wrap_now[g])
    );
  end

  // Guard is shared, so any slice reaching its period boundary refreshes it.
  always_comb begin
    guard_d = guard_q;
    if (evt == EVT_CFG_LOAD || (|wrap_now)) guard_d = guard_time;
    slice_en_d = hit | {NUM_SLICE{!sched_enable}};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      guard_q    <= '0;
      slice_en_q <= '1;
    end else begin
      guard_q    <= guard_d;
      slice_en_q <= slice_en_d;
    end
  end

  assign slice_en0   = slice_en_q[0];
  assign slice_en1   = slice_en_q[1];
  assign slice_en2   = slice_en_q[2];
  assign slice_en3   = slice_en_q[3];
  assign slice_wrap0 = wrap[0];
  assign slice_wrap1 = wrap[1];
  assign slice_wrap2 = wrap[2];
  assign slice_wrap3 = wrap[3];

endmodule
